// File: rtl/div_32b_unsigned_if.sv
// rtl/div_32b_unsigned_if.sv - start/operand/result bundle between the AU decoder and the divider
interface div_32b_unsigned_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        dbz;

    modport master (output start, a, b, input busy, done, hi, lo, zero, dbz);
    modport slave  (input start, a, b, output busy, done, hi, lo, zero, dbz);
endinterface

// File: rtl/div_32b_unsigned.sv
// rtl/div_32b_unsigned.sv - 32-bit unsigned restoring divider, hi=remainder lo=quotient
// Optional: DIV_ZERO_DETECT_EN short-circuits b==0 to a one-cycle result with dbz set.
module div_32b_unsigned (
    input  logic                  clk,
    input  logic                  rst,
    div_32b_unsigned_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state, state_nx;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [5:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        zero_q;
    logic        dbz_q;

    logic        accept;
    logic        last;
    logic        b_is_zero;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        ge;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic        unused_rem_msb;

    // T can reach 2*D-1, so the compare and subtract are done at 33 bits.
    assign trial  = {rem[31:0], quo[31]};
    assign ge     = trial >= {1'b0, dvs};
    assign diff   = trial - {1'b0, dvs};
    assign rem_nx = ge ? diff : trial;
    assign quo_nx = {quo[30:0], ge};
    assign last   = (cnt == 6'd31);
    assign accept = (state != S_RUN) && bus.start;
    assign b_is_zero = (bus.b == 32'd0);
    assign unused_rem_msb = rem[32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
`ifdef DIV_ZERO_DETECT_EN
                    state_nx = b_is_zero ? S_DONE : S_RUN;
`else
                    state_nx = S_RUN;
`endif
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RUN:   if (last) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem    <= 33'd0;
            quo    <= 32'd0;
            dvs    <= 32'd0;
            cnt    <= 6'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            zero_q <= 1'b1;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            rem   <= 33'd0;
            quo   <= bus.a;
            dvs   <= bus.b;
            cnt   <= 6'd0;
            dbz_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            if (b_is_zero) begin
                hi_q   <= bus.a;
                lo_q   <= 32'hFFFF_FFFF;
                zero_q <= 1'b0;
                dbz_q  <= 1'b1;
            end
`endif
        end else if (state == S_RUN) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 6'd1;
            if (last) begin
                hi_q   <= rem_nx[31:0];
                lo_q   <= quo_nx;
                zero_q <= (quo_nx == 32'd0);
            end
        end
    end

    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.zero = zero_q;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.dbz  = dbz_q;
`else
    assign bus.dbz  = 1'b0;
`endif
endmodule

// File: tb/tb_div_32b_unsigned.sv
// tb/tb_div_32b_unsigned.sv - self-checking bench for div_32b_unsigned
module tb_div_32b_unsigned;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    div_32b_unsigned_if bus();

    div_32b_unsigned dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: result = plain division, timing = edges remaining until completion.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, ca, cb;
    logic        m_zero = 1'b1, m_dbz = 1'b0, m_done = 1'b0;
    int          m_rem = 0;

    task automatic m_commit();
        m_lo   = (cb == 32'd0) ? 32'hFFFF_FFFF : ca / cb;
        m_hi   = (cb == 32'd0) ? ca : ca % cb;
        m_zero = (m_lo == 32'd0);
        m_dbz  = DZ && (cb == 32'd0);
        m_done = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_zero = 1'b1; m_dbz = 1'b0;
            m_done = 1'b0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_commit();
            end else if (bus.start) begin
                ca = bus.a;
                cb = bus.b;
                m_dbz = 1'b0;
                if (DZ && bus.b == 32'd0) m_commit();
                else m_rem = 32;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            if ({bus.busy, bus.done, bus.hi, bus.lo, bus.zero, bus.dbz} !==
                {(m_rem > 0), m_done, m_hi, m_lo, m_zero, m_dbz}) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: busy/done/hi/lo/zero/dbz got %b/%b/%h/%h/%b/%b expected %b/%b/%h/%h/%b/%b",
                         $time, bus.busy, bus.done, bus.hi, bus.lo, bus.zero, bus.dbz,
                         (m_rem > 0), m_done, m_hi, m_lo, m_zero, m_dbz);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_zero, input logic exp_dbz, input int exp_lat);
        int lat, nbusy;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; nbusy = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, nbusy, exp_lat);
        check({tag, " lo"}, bus.lo, exp_lo);
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
        check({tag, " dbz"}, {31'd0, bus.dbz}, {31'd0, exp_dbz});
    endtask

    task automatic run_held(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                            input logic [31:0] next_a, input logic [31:0] next_b);
        int lat;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!bus.done && lat < 40) begin
            bus.a = $urandom;
            bus.b = $urandom;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 32);
        check({tag, " lo"}, bus.lo, exp_lo);
        check({tag, " hi"}, bus.hi, exp_hi);
        bus.a = next_a;
        bus.b = next_b;
    endtask

    initial begin
        bus.start = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
        #12 rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset zero", {31'd0, bus.zero}, 32'd1);
        check("reset dbz", {31'd0, bus.dbz}, 32'd0);

        run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32);
        run_op("ffffffff/80000000", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 32);
        run_op("ffffffff/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32);
        run_op("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b1, 1'b0, 32);
        run_op("1234/0", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b0, DZ, DZ ? 0 : 32);
        run_op("80000001/fffffffe", 32'h8000_0001, 32'hFFFF_FFFE, 32'd0, 32'h8000_0001, 1'b1, 1'b0, 32);

        // Abort during iteration 10 with an asynchronous reset pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        check("abort zero", {31'd0, bus.zero}, 32'd1);
        check("abort dbz", {31'd0, bus.dbz}, 32'd0);
        #1 rst = 1'b0;
        run_op("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 32);

        // start held high through RUN with operands scrambled; back-to-back via DONE.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd50; bus.b = 32'd5;
        run_held("held 50/5", 32'd10, 32'd0, 32'd77, 32'd7);
        run_held("held 77/7", 32'd11, 32'd0, 32'd0, 32'd1);
        bus.start = 1'b0;

        // Randomised traffic, checked every cycle by the model.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.a = $urandom;
            case ($urandom_range(0, 4))
                0:       bus.b = 32'd0;
                1:       bus.b = 32'h8000_0000 | $urandom;
                2:       bus.b = $urandom_range(1, 15);
                3:       bus.b = $urandom >> $urandom_range(0, 31);
                default: bus.b = $urandom;
            endcase
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.start = 1'b0;
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
